// File: rtl/edge_capture_pkg.sv
// edge_capture_pkg: shared types and helpers for the edge capture block.
//   edge_mode_e : per-channel edge selection (off / rise / fall / both)
//   popcount    : number of set bits in a vector of up to PopMaxW bits
//   sat_add     : unsigned add that clamps at 2^w-1 instead of wrapping
package edge_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Widest vector popcount accepts; narrower callers zero-extend.
  localparam int unsigned PopMaxW = 1024;

  function automatic int unsigned popcount(input logic [PopMaxW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PopMaxW; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // a + b, clamped to 2^w-1. The 64-bit sum cannot overflow for w < 63.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_val;
    logic [63:0] sum;
    max_val = (64'd1 << w) - 64'd1;
    sum     = a + b;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/edge_capture_filter.sv
// edge_capture_filter: single-channel glitch filter.
// The output follows the raw input only after raw has differed from the
// output for FILT_LEN consecutive cycles; any interruption restarts the run.
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   prime_i  priming cycle: load filt from raw and zero the run counter
//   raw_i    unfiltered input bit
//   filt_o   filtered output bit (registered)
module edge_capture_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic prime_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (prime_i) begin
      cnt_q  <= '0;
      filt_q <= raw_i;
    end else if (raw_i != filt_q) begin
      // This cycle completes FILT_LEN consecutive differing samples.
      if (cnt_q == CntW'(FILT_LEN - 1)) begin
        cnt_q  <= '0;
        filt_q <= raw_i;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/edge_capture_ctrl.sv
// edge_capture_ctrl: multi-channel edge capture with per-bit edge mode,
// sticky W1C status, maskable registered IRQ and a saturating edge counter.
// Optional feature macro: EDGE_FILTER_EN inserts a per-bit glitch filter
// (edge_capture_filter, FILT_LEN cycles) in front of edge detection.
// Ports:
//   clk        clock
//   reset_n    synchronous active-low reset
//   data_i     raw input channels
//   mode_i     per-channel edge_mode_e, bits [2i+1:2i] for channel i
//   mask_i     1 = channel contributes to irq_o
//   clear_i    W1C pulse per channel for the sticky status
//   cnt_clr_i  clears evt_cnt_o (wins over same-cycle edges)
//   edge_o     sticky status, includes edges detected this cycle
//   irq_o      registered interrupt level
//   evt_cnt_o  saturating count of detected edges over all channels
module edge_capture_ctrl
  import edge_capture_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     mask_i,
  input  logic [WIDTH-1:0]     clear_i,
  input  logic                 cnt_clr_i,
  output logic [WIDTH-1:0]     edge_o,
  output logic                 irq_o,
  output logic [COUNT_W-1:0]   evt_cnt_o
);

  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   cap_q;
  logic               primed_q;
  logic               irq_q;
  logic [COUNT_W-1:0] cnt_q;

  logic [WIDTH-1:0]   samp;
  logic [WIDTH-1:0]   det;
  logic [COUNT_W-1:0] cnt_next;

`ifdef EDGE_FILTER_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    edge_capture_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .prime_i (~primed_q),
      .raw_i   (data_i[gi]),
      .filt_o  (samp[gi])
    );
  end
`else
  assign samp = data_i;
  logic unused_filt_len;
  assign unused_filt_len = |FILT_LEN;
`endif

  // No detection until data_q holds a real sample of the inputs.
  always_comb begin
    det = '0;
    if (primed_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (edge_mode_e'(mode_i[2*i +: 2]))
          EDGE_RISE: det[i] = ~data_q[i] &  samp[i];
          EDGE_FALL: det[i] =  data_q[i] & ~samp[i];
          EDGE_BOTH: det[i] =  data_q[i] ^  samp[i];
          default:   det[i] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    cnt_next = COUNT_W'(sat_add(64'(cnt_q), 64'(popcount(PopMaxW'(det))), COUNT_W));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= '0;
      cap_q    <= '0;
      primed_q <= 1'b0;
      irq_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      primed_q <= 1'b1;
      // Priming samples the raw inputs so the filter and data_q start aligned.
      data_q   <= primed_q ? samp : data_i;
      cap_q    <= det | (cap_q & ~clear_i);
      irq_q    <= |((det | (cap_q & ~clear_i)) & mask_i);
      cnt_q    <= cnt_clr_i ? '0 : cnt_next;
    end
  end

  assign edge_o    = cap_q | det;
  assign irq_o     = irq_q;
  assign evt_cnt_o = cnt_q;

endmodule

// File: tb/tb_edge_capture_ctrl.sv
module tb_edge_capture_ctrl;

  localparam int unsigned W      = 32;
  localparam int unsigned CW     = 16;
  localparam int unsigned FL     = 4;
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [W-1:0]      data_i;
  logic [2*W-1:0]    mode_i;
  logic [W-1:0]      mask_i;
  logic [W-1:0]      clear_i;
  logic              cnt_clr_i;
  logic [W-1:0]      edge_o;
  logic              irq_o;
  logic [CW-1:0]     evt_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  edge_capture_ctrl #(
    .WIDTH    (W),
    .COUNT_W  (CW),
    .FILT_LEN (FL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_i    (data_i),
    .mode_i    (mode_i),
    .mask_i    (mask_i),
    .clear_i   (clear_i),
    .cnt_clr_i (cnt_clr_i),
    .edge_o    (edge_o),
    .irq_o     (irq_o),
    .evt_cnt_o (evt_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit           m_primed = 1'b0;
  logic [W-1:0] m_prev   = '0;   // last value seen by the detector
  logic [W-1:0] m_cap    = '0;
  logic [W-1:0] m_filt   = '0;
  bit           m_irq    = 1'b0;
  int unsigned  m_cnt    = 0;
  logic [W-1:0] m_hist[$];       // raw samples since priming, newest last

  function automatic logic [W-1:0] m_eff();
`ifdef EDGE_FILTER_EN
    return m_filt;
`else
    return data_i;
`endif
  endfunction

  function automatic logic [W-1:0] m_det(input logic [W-1:0] eff);
    logic [W-1:0] d;
    d = '0;
    if (m_primed) begin
      for (int i = 0; i < W; i++) begin
        bit r, f;
        r = (m_prev[i] == 1'b0) && (eff[i] == 1'b1);
        f = (m_prev[i] == 1'b1) && (eff[i] == 1'b0);
        case (mode_i[2*i +: 2])
          2'd1:    d[i] = r;
          2'd2:    d[i] = f;
          2'd3:    d[i] = r || f;
          default: d[i] = 1'b0;
        endcase
      end
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_update
    logic [W-1:0] eff, det, nf;
    int unsigned  sum;
    bit           all_diff;
    eff = m_eff();
    det = m_det(eff);
    if (!reset_n) begin
      m_primed <= 1'b0;
      m_prev   <= '0;
      m_cap    <= '0;
      m_filt   <= '0;
      m_irq    <= 1'b0;
      m_cnt    <= 0;
      m_hist.delete();
    end else if (!m_primed) begin
      m_primed <= 1'b1;
      m_prev   <= data_i;
      m_filt   <= data_i;
      m_hist.delete();
    end else begin
      sum = m_cnt + $countones(det);
      m_irq  <= |((det | (m_cap & ~clear_i)) & mask_i);
      m_cap  <= det | (m_cap & ~clear_i);
      m_cnt  <= cnt_clr_i ? 0 : ((sum > CntMax) ? CntMax : sum);
      m_prev <= eff;
      // Filter output flips once the last FL raw samples all disagree with it.
      m_hist.push_back(data_i);
      if (m_hist.size() > FL) void'(m_hist.pop_front());
      nf = m_filt;
      if (m_hist.size() == FL) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_filt[i]) all_diff = 1'b0;
          if (all_diff) nf[i] = data_i[i];
        end
      end
      m_filt <= nf;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("edge_o", 64'(edge_o), 64'(m_cap | m_det(m_eff())));
      check("irq_o", 64'(irq_o), 64'(m_irq));
      check("evt_cnt_o", 64'(evt_cnt_o), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode_i[2*ch +: 2] = m;
  endtask

  initial begin
    reset_n   = 1'b0;
    data_i    = '1;
    mode_i    = '1;
    mask_i    = '0;
    clear_i   = '0;
    cnt_clr_i = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset edge_o", 64'(edge_o), 64'd0);
    check("reset irq_o", 64'(irq_o), 64'd0);
    check("reset evt_cnt_o", 64'(evt_cnt_o), 64'd0);

    // 1: inputs high out of reset must not look like rising edges
    reset_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("prime edge_o", 64'(edge_o), 64'd0);
    check("prime evt_cnt_o", 64'(evt_cnt_o), 64'd0);

`ifndef EDGE_FILTER_EN
    // 2: ch3 rise, mask, clear
    mode_i = '0;
    set_mode(3, 2'b01);
    data_i = '0;
    tick();
    data_i[3] = 1'b1;
    mask_i[3] = 1'b1;
    @(negedge clk);
    check("t2 edge same cycle", 64'(edge_o[3]), 64'd1);
    check("t2 irq not yet", 64'(irq_o), 64'd0);
    tick();
    @(negedge clk);
    check("t2 irq next cycle", 64'(irq_o), 64'd1);
    clear_i[3] = 1'b1;
    tick();
    clear_i = '0;
    @(negedge clk);
    check("t2 edge cleared", 64'(edge_o[3]), 64'd0);
    check("t2 irq dropped", 64'(irq_o), 64'd0);

    // 3: ch5 fall with coincident clear: set wins
    set_mode(5, 2'b10);
    data_i[5] = 1'b1;
    tick();
    data_i[5]  = 1'b0;
    clear_i[5] = 1'b1;
    tick();
    clear_i = '0;
    @(negedge clk);
    check("t3 set wins", 64'(edge_o[5]), 64'd1);
    check("t3 count", 64'(evt_cnt_o), 64'd2);

    // 4: OFF channel ignores toggles; masked-off edges raise no irq
    set_mode(7, 2'b00);
    for (int k = 0; k < 4; k++) begin
      data_i[7] = ~data_i[7];
      tick();
      @(negedge clk);
      check("t4 off channel", 64'(edge_o[7]), 64'd0);
    end
    mask_i  = '0;
    clear_i = '1;
    mode_i  = '1;
    tick();
    clear_i = '0;
    tick();
    data_i = ~data_i;
    @(negedge clk);
    check("t4 all edges", 64'(edge_o), 64'(32'hFFFF_FFFF));
    tick();
    @(negedge clk);
    check("t4 masked irq", 64'(irq_o), 64'd0);

    // 5: saturation, then clear beats a coincident edge
    for (int k = 0; k < 2100; k++) begin
      data_i = ~data_i;
      tick();
    end
    @(negedge clk);
    check("t5 saturated", 64'(evt_cnt_o), 64'hFFFF);
    data_i    = ~data_i;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    @(negedge clk);
    check("t5 cleared", 64'(evt_cnt_o), 64'd0);
    tick();
`else
    // 6: glitch filter on ch0
    mode_i  = '1;
    data_i  = '0;
    clear_i = '1;
    repeat (8) tick();
    clear_i = '0;
    tick();
    data_i[0] = 1'b1;
    repeat (3) tick();
    data_i[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("t6 short pulse", 64'(edge_o[0]), 64'd0);
    end
    data_i[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      check("t6 filtered rise", 64'(edge_o[0]), (k == 4) ? 64'd1 : 64'd0);
    end
    data_i[0] = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("t6 reset edge_o", 64'(edge_o), 64'd0);
    check("t6 reset irq_o", 64'(irq_o), 64'd0);
    check("t6 reset evt_cnt_o", 64'(evt_cnt_o), 64'd0);
    reset_n = 1'b1;
    tick();
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) data_i = data_i ^ ($urandom & $urandom);
      if (n % 50 == 0) mode_i = {$urandom, $urandom};
      if (n % 37 == 0) mask_i = $urandom;
      clear_i   = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      cnt_clr_i = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset_n = 1'b1;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
